// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//
// Execution controller for the 5-stage MIPS pipeline. Sequences continuous
// run, single-step, stop and HALT drain under debug-unit command, and merges
// hazard-unit stall and branch-flush requests into per-stage load enables,
// the IF/ID flush and the ID/EX bubble insert.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   run_cmd_i             pulse: start continuous execution
//   step_cmd_i            pulse: execute exactly one pipeline cycle
//   stop_cmd_i            pulse: freeze pipeline (resumable)
//   halt_signal_i         HALT opcode present in ID
//   stall_i               load-use stall request
//   branch_taken_i        branch/jump resolved taken in ID
//   pc_write_o            PC load enable
//   if_dec_write_o        IF/ID load enable
//   pipe_enable_o         ID/EX, EX/MEM, MEM/WB load enable
//   if_dec_flush_o        clear IF/ID to NOP
//   dec_ex_bubble_o       load NOP control into ID/EX
//   step_done_o           pulse: step cycle executed
//   halted_o              program finished, pipeline drained
//   state_o               current state encoding
//   cycle_count_o         executed pipeline cycles (saturating)
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int NB_CYCLES    = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_STATE     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run_cmd_i,
  input  logic                 step_cmd_i,
  input  logic                 stop_cmd_i,
  input  logic                 halt_signal_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  output logic                 pc_write_o,
  output logic                 if_dec_write_o,
  output logic                 pipe_enable_o,
  output logic                 if_dec_flush_o,
  output logic                 dec_ex_bubble_o,
  output logic                 step_done_o,
  output logic                 halted_o,
  output logic [NB_STATE-1:0]  state_o,
  output logic [NB_CYCLES-1:0] cycle_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [3:0]           DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [NB_CYCLES-1:0] CNT_MAX    = {NB_CYCLES{1'b1}};
  localparam logic [NB_CYCLES-1:0] CNT_ONE    = {{(NB_CYCLES-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [3:0]           drain_cnt_r;
  logic [NB_CYCLES-1:0] cycle_cnt_r;

  logic pc_write_s;
  logic if_dec_write_s;
  logic pipe_enable_s;
  logic if_dec_flush_s;
  logic dec_ex_bubble_s;
  logic step_done_s;
  logic halted_s;
  logic hold_front_s;

  // A stall or a HALT in ID both freeze PC and IF/ID and push a bubble into ID/EX.
  assign hold_front_s = stall_i | halt_signal_i;

  // State sequencing and drain countdown.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run_cmd_i) begin
            state_r <= ST_RUN;
          end else if (step_cmd_i) begin
            state_r <= ST_STEP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (halt_signal_i) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end else if (stop_cmd_i) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          // A HALT seen during a step still drains to completion.
          if (halt_signal_i) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // Leaving on count 1 makes DRAIN last exactly DRAIN_CYCLES cycles.
          if (drain_cnt_r <= 4'd1) begin
            state_r     <= ST_HALTED;
            drain_cnt_r <= 4'd0;
          end else begin
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          state_r     <= ST_IDLE;
          drain_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Executed-cycle counter: counts every advancing or draining cycle, saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_r <= {NB_CYCLES{1'b0}};
    end else if (pipe_enable_s && (cycle_cnt_r != CNT_MAX)) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  // Per-state decode of pipeline controls; no added latency on hazard inputs.
  always_comb begin
    pc_write_s      = 1'b0;
    if_dec_write_s  = 1'b0;
    pipe_enable_s   = 1'b0;
    if_dec_flush_s  = 1'b0;
    dec_ex_bubble_s = 1'b0;
    step_done_s     = 1'b0;
    halted_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pipe_enable_s = 1'b0;
      end
      ST_RUN, ST_STEP: begin
        pipe_enable_s   = 1'b1;
        pc_write_s      = ~hold_front_s;
        if_dec_write_s  = ~hold_front_s;
        dec_ex_bubble_s = hold_front_s;
        // Stall wins over flush: the branch re-resolves once the stall clears.
        if_dec_flush_s  = branch_taken_i & ~hold_front_s;
        step_done_s     = (state_r == ST_STEP);
      end
      ST_DRAIN: begin
        pipe_enable_s   = 1'b1;
        dec_ex_bubble_s = 1'b1;
      end
      ST_HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        pipe_enable_s = 1'b0;
      end
    endcase
  end

  assign pc_write_o      = pc_write_s;
  assign if_dec_write_o  = if_dec_write_s;
  assign pipe_enable_o   = pipe_enable_s;
  assign if_dec_flush_o  = if_dec_flush_s;
  assign dec_ex_bubble_o = dec_ex_bubble_s;
  assign step_done_o     = step_done_s;
  assign halted_o        = halted_s;
  assign state_o         = NB_STATE'(state_r);
  assign cycle_count_o   = cycle_cnt_r;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Top-level execution controller for the 5-stage MIPS pipeline. It sequences run, single-step, stop and HALT drain under debug-unit command, and merges hazard-unit stall and branch-flush requests into per-stage enable, flush and bubble controls. It sits between the debug unit, the hazard unit and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers plus the PC.

Parameters:
NB_CYCLES, 32, width of executed-cycle counter
DRAIN_CYCLES, 4, cycles needed after HALT decode to retire ID..WB (range 1..15)
NB_STATE, 3, width of state_o

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
run_cmd_i  in  1  one-cycle pulse: start continuous execution
step_cmd_i  in  1  one-cycle pulse: execute exactly one pipeline cycle
stop_cmd_i  in  1  one-cycle pulse: freeze pipeline, resumable
halt_signal_i  in  1  HALT opcode present in ID stage
stall_i  in  1  load-use stall request from hazard unit
branch_taken_i  in  1  branch/jump resolved taken in ID; IF/ID holds wrong-path instruction
pc_write_o  out  1  PC load enable
if_dec_write_o  out  1  IF/ID register load enable
pipe_enable_o  out  1  load enable for ID/EX, EX/MEM, MEM/WB
if_dec_flush_o  out  1  clear IF/ID to NOP on this edge
dec_ex_bubble_o  out  1  load NOP control into ID/EX on this edge
step_done_o  out  1  one-cycle pulse: step cycle executed
halted_o  out  1  program finished, pipeline drained
state_o  out  NB_STATE  current state encoding
cycle_count_o  out  NB_CYCLES  executed pipeline cycles

Behaviour:
- States (encoding): IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Other codes: next state IDLE, all enables 0.
- Reset: state IDLE, cycle_count_o=0, drain counter=0. All outputs 0, except state_o=0.
- Commands are sampled in the current state and take effect from the next cycle. Outputs are combinational decodes of the registered state and current stall_i/halt_signal_i/branch_taken_i; no added latency.
- "Advancing" means state is RUN or STEP.
- IDLE: all enables 0.
  - Command priority: run > step; stop is ignored.
  - run_cmd_i -> RUN; step_cmd_i -> STEP.
- RUN and STEP enables:
  - pipe_enable_o=1.
  - pc_write_o = if_dec_write_o = ~stall_i & ~halt_signal_i.
  - dec_ex_bubble_o = stall_i | halt_signal_i.
  - if_dec_flush_o = branch_taken_i & ~stall_i & ~halt_signal_i. Stall has priority over flush; the branch re-resolves after the stall.
- RUN transitions, priority halt > stop:
  - halt_signal_i -> DRAIN, drain counter loaded with DRAIN_CYCLES.
  - stop_cmd_i -> IDLE.
  - run_cmd_i and step_cmd_i are ignored.
- STEP: lasts exactly one cycle with step_done_o=1.
  - halt_signal_i -> DRAIN; otherwise -> IDLE.
  - Commands are ignored.
- DRAIN: pc_write_o=0, if_dec_write_o=0, pipe_enable_o=1, dec_ex_bubble_o=1, if_dec_flush_o=0.
  - Counter decrements each cycle. When counter==1 -> HALTED, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  - The drain completes even if entered from STEP. All commands are ignored.
- HALTED: all enables 0, halted_o=1. Only reset exits this state.
- cycle_count_o: +1 on every cycle with pipe_enable_o=1 (RUN, STEP, DRAIN). Saturates at all-ones with no wrap.
- Reset asserted in any state, including mid-DRAIN: on the next edge, reset values apply and reset overrides every command.

Test Plan:
- Reset, then run_cmd_i pulse, 10 cycles with no hazards -> state_o=1 from cycle 1; pc_write_o=if_dec_write_o=pipe_enable_o=1; cycle_count_o=10.
- In RUN, stall_i=1 for 1 cycle together with branch_taken_i=1 -> that cycle pc_write_o=0, if_dec_write_o=0, dec_ex_bubble_o=1, if_dec_flush_o=0; next cycle with branch_taken_i=1, stall_i=0 -> if_dec_flush_o=1.
- Three step_cmd_i pulses spaced 5 cycles apart from IDLE -> exactly 3 single-cycle STEP visits; step_done_o pulses 3 times; cycle_count_o=3.
- In RUN, halt_signal_i=1 (DRAIN_CYCLES=4) -> 4 DRAIN cycles with pc_write_o=0 and pipe_enable_o=1, then halted_o=1 permanently; a later run_cmd_i has no effect.
- run_cmd_i and step_cmd_i asserted together in IDLE -> RUN. In RUN, stop_cmd_i and halt_signal_i asserted together -> DRAIN.
- Reset asserted during the 2nd DRAIN cycle -> next cycle state_o=0, halted_o=0, cycle_count_o=0, all enables 0.
